// File: rtl/amp_enable_ctrl.sv
// Amplifier enable sequencer: IDLE -> SETTLE (bias precharge) -> ON, with a latched FAULT state.
// Optional host watchdog enabled by defining AMP_WDOG_EN; the port list is identical either way.
module amp_enable_ctrl #(
  parameter logic [23:0] SETTLE_CYCLES = 24'd49152,
  parameter logic [23:0] WDOG_CYCLES   = 24'd4915200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_req,
  input  logic       fault_in,
  input  logic       fault_clr,
  input  logic       wdog_refresh,
  output logic       amp_enable,
  output logic       pre_enable,
  output logic       fault_latched,
  output logic       wdog_trip,
  output logic [7:0] fault_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    ON     = 2'b10,
    FAULT  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]  fault_cnt_q, fault_cnt_d;
  logic        wdog_trip_q, wdog_trip_d;
  logic        amp_enable_q, amp_enable_d;
  logic        pre_enable_q, pre_enable_d;
  logic        fault_latched_q, fault_latched_d;
  logic        wdog_timeout;

`ifdef AMP_WDOG_EN
  logic [23:0] wdog_cnt_q, wdog_cnt_d;

  // A refresh landing on the expiry cycle still counts as a refresh.
  assign wdog_timeout = !wdog_refresh && (wdog_cnt_q == WDOG_CYCLES - 24'd1);

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if ((state_q == IDLE && state_d == SETTLE) || wdog_refresh) begin
      wdog_cnt_d = '0;
    end else if (state_q == SETTLE || state_q == ON) begin
      wdog_cnt_d = wdog_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) wdog_cnt_q <= '0;
    else        wdog_cnt_q <= wdog_cnt_d;
  end
`else
  logic unused_wdog;
  assign unused_wdog  = wdog_refresh | (|WDOG_CYCLES);
  assign wdog_timeout = 1'b0;
`endif

  // Next-state logic; branch order in SETTLE/ON encodes the same-cycle priority.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    wdog_trip_d  = wdog_trip_q;
    case (state_q)
      IDLE: begin
        if (enable_req) begin
          if (fault_in) begin
            state_d = FAULT;
          end else begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
      end
      SETTLE, ON: begin
        if (fault_in) begin
          state_d = FAULT;
        end else if (wdog_timeout) begin
          state_d     = FAULT;
          wdog_trip_d = 1'b1;
        end else if (!enable_req) begin
          state_d = IDLE;
        end else if (state_q == SETTLE) begin
          if (settle_cnt_q == SETTLE_CYCLES - 24'd1) state_d = ON;
          settle_cnt_d = settle_cnt_q + 24'd1;
        end
      end
      FAULT: begin
        if (fault_clr && !fault_in && !enable_req) begin
          state_d     = IDLE;
          wdog_trip_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == FAULT && state_q != FAULT && fault_cnt_q != 8'hFF) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state so they register on the transition edge.
  always_comb begin
    amp_enable_d    = (state_d == ON);
    pre_enable_d    = (state_d == SETTLE) || (state_d == ON);
    fault_latched_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it is only seen on a clock edge.
    if (!reset) begin
      state_q         <= IDLE;
      settle_cnt_q    <= '0;
      fault_cnt_q     <= '0;
      wdog_trip_q     <= 1'b0;
      amp_enable_q    <= 1'b0;
      pre_enable_q    <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      fault_cnt_q     <= fault_cnt_d;
      wdog_trip_q     <= wdog_trip_d;
      amp_enable_q    <= amp_enable_d;
      pre_enable_q    <= pre_enable_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign amp_enable    = amp_enable_q;
  assign pre_enable    = pre_enable_q;
  assign fault_latched = fault_latched_q;
  assign wdog_trip     = wdog_trip_q;
  assign fault_cnt     = fault_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_amp_enable_ctrl.sv
// Self-checking bench for amp_enable_ctrl (SETTLE_CYCLES=4, WDOG_CYCLES=8).
// Builds with or without AMP_WDOG_EN; watchdog expectations follow the macro.
module tb_amp_enable_ctrl;

  localparam int S = 4;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_req = 1'b0;
  logic       fault_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic       wdog_refresh = 1'b0;
  logic       amp_enable, pre_enable, fault_latched, wdog_trip;
  logic [7:0] fault_cnt;
  logic [1:0] state;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  cmp_en = 1'b0;

  amp_enable_ctrl #(.SETTLE_CYCLES(24'd4), .WDOG_CYCLES(24'd8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_req   (enable_req),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .wdog_refresh (wdog_refresh),
    .amp_enable   (amp_enable),
    .pre_enable   (pre_enable),
    .fault_latched(fault_latched),
    .wdog_trip    (wdog_trip),
    .fault_cnt    (fault_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Model: a session has an age (edges since it began) and a watchdog age
  // (edges since start or last refresh); ON is simply "age has reached S".
  int m_mode = 0;   // 0 idle, 1 session, 2 fault
  int m_age  = 0;
  int m_wd   = 0;
  int m_cnt  = 0;
  bit m_trip = 1'b0;
  bit wd_on;

`ifdef AMP_WDOG_EN
  assign wd_on = 1'b1;
`else
  assign wd_on = 1'b0;
`endif

  always @(posedge clk) begin
    if (!reset) begin
      m_mode <= 0; m_age <= 0; m_wd <= 0; m_cnt <= 0; m_trip <= 1'b0;
    end else if (m_mode == 0) begin
      if (enable_req && fault_in) begin
        m_mode <= 2; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (enable_req) begin
        m_mode <= 1; m_age <= 0; m_wd <= 0;
      end
    end else if (m_mode == 1) begin
      if (fault_in || (wd_on && !wdog_refresh && m_wd >= W - 1)) begin
        m_mode <= 2; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        m_trip <= !fault_in;
      end else if (!enable_req) begin
        m_mode <= 0;
      end else begin
        m_age <= m_age + 1;
        m_wd  <= wdog_refresh ? 0 : m_wd + 1;
      end
    end else if (fault_clr && !fault_in && !enable_req) begin
      m_mode <= 0; m_trip <= 1'b0;
    end
  end

  function automatic logic [13:0] model_vec();
    logic [1:0] st;
    st = (m_mode == 0) ? 2'd0 : (m_mode == 2) ? 2'd3 : (m_age >= S) ? 2'd2 : 2'd1;
    return {st, st == 2'd2, st == 2'd1 || st == 2'd2, st == 2'd3, m_trip, 8'(m_cnt)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle_outputs",
            32'({state, amp_enable, pre_enable, fault_latched, wdog_trip, fault_cnt}),
            32'(model_vec()));
  end

  // Apply inputs just after a falling edge; return after the next falling edge.
  task automatic step(input logic en, input logic fin, input logic clr, input logic rfr);
    enable_req = en; fault_in = fin; fault_clr = clr; wdog_refresh = rfr;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1, 1, 1, 0);            // reset held with everything else active
    cmp_en = 1'b1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'({amp_enable, pre_enable, fault_latched, wdog_trip, fault_cnt}), 32'd0);
    reset = 1'b1;
    step(0, 0, 0, 0);

    // Enable sequence
    step(1, 0, 0, 0);
    check("settle_entry_state", 32'(state), 32'd1);
    check("settle_entry_pre", 32'({pre_enable, amp_enable}), 32'b10);
    repeat (3) step(1, 0, 0, 0);
    check("settle_last_cycle", 32'({state, amp_enable}), 32'b010);
    step(1, 0, 0, 0);
    check("on_after_settle", 32'({state, amp_enable, pre_enable}), 32'b1011);

    // Fault in ON, clear rules
    step(1, 1, 0, 0);
    check("fault_from_on", 32'({state, amp_enable, fault_latched, fault_cnt}), {22'd0, 2'd3, 1'b0, 1'b1, 8'd1});
    step(1, 0, 1, 0);
    check("clr_with_enable_ignored", 32'(state), 32'd3);
    step(0, 0, 0, 0);
    check("clr_not_remembered", 32'(state), 32'd3);
    step(0, 0, 1, 0);
    check("clr_to_idle", 32'({state, fault_latched, fault_cnt}), {21'd0, 2'd0, 1'b0, 8'd1});

    // Simultaneous fault and enable drop in SETTLE
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("fault_beats_drop", 32'({state, fault_cnt}), {22'd0, 2'd3, 8'd2});
    step(0, 1, 1, 0);
    check("clr_while_fault_in", 32'(state), 32'd3);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("sim_clear_idle", 32'(state), 32'd0);

    // Watchdog without refresh
    step(1, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0);
    check("wdog_before_expiry", 32'({state, wdog_trip}), 32'b100);
    step(1, 0, 0, 0);
`ifdef AMP_WDOG_EN
    check("wdog_expiry", 32'({state, wdog_trip, fault_cnt}), {21'd0, 2'd3, 1'b1, 8'd3});
`else
    check("wdog_absent", 32'({state, wdog_trip, fault_cnt}), {21'd0, 2'd2, 1'b0, 8'd2});
`endif
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("wdog_trip_cleared", 32'({state, wdog_trip}), 32'b000);

    // Watchdog with refresh every 5 cycles
    step(1, 0, 0, 0);
    for (int i = 1; i <= 40; i++) step(1, 0, 0, (i % 5) == 0);
    check("refresh_keeps_on", 32'({state, wdog_trip, amp_enable}), 32'b1001);
    step(0, 0, 0, 0);
    check("drop_to_idle", 32'({state, pre_enable}), 32'b000);

    // Fault counter saturation
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    check("cnt_saturated", 32'(fault_cnt), 32'hFF);
    step(1, 1, 0, 0);
    check("cnt_holds", 32'({state, fault_cnt}), {22'd0, 2'd3, 8'hFF});
    step(0, 0, 1, 0);

    // Reset in ON overrides a pending fault_clr
    repeat (5) step(1, 0, 0, 0);
    check("on_before_reset", 32'(amp_enable), 32'd1);
    reset = 1'b0;
    step(1, 0, 1, 0);
    check("reset_in_on", 32'({state, amp_enable, pre_enable, fault_cnt}), 32'd0);
    reset = 1'b1;

    // Reset mid-SETTLE
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 0, 0);
    check("reset_in_settle", 32'({state, pre_enable}), 32'd0);
    reset = 1'b1;
    step(0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
